// File: rtl/sclk_link_pkg.sv
// Frame constants and FSM state encoding shared by the synchronous serial link
// transmitter and receiver.
package sclk_link_pkg;

    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;
    localparam logic PARITY_EVEN = 1'b1;
    localparam logic MSB_FIRST   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } link_state_e;

endpackage

// File: rtl/sclk_frame_rx_if.sv
// Valid/ready word interface between the serial frame receiver and its consumer.
interface sclk_frame_rx_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/sig_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input with a registered rising-edge pulse.
module sig_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_d;

    // Loaded with 1 so an idle-high line never produces a spurious edge out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync   <= '1;
            sync_d <= 1'b1;
            rise   <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], din};
            sync_d <= sync[SYNC_STAGES-1];
            rise   <= sync[SYNC_STAGES-1] & ~sync_d;
        end
    end
endmodule

// File: rtl/sclk_frame_rx.sv
// Synchronous serial link receiver: frames rxsd on rxck rising edges, checks parity/stop,
// and hands each good word to a valid/ready consumer with sticky error flags.
module sclk_frame_rx
    import sclk_link_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rxsd,
    input  logic                   rxck,
    sclk_frame_rx_if.master        rx,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   overrun,
    output logic [7:0]             frame_cnt,
    output logic                   busy
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic                 rck_rise;
    logic [SYNC_STAGES:0] sd_pipe;
    logic                 sd;
    link_state_e          state, state_nxt;
    logic [CW-1:0]        bit_cnt;
    logic [TW-1:0]        to_cnt;
    logic [DATA_W-1:0]    shreg;
    logic                 par_bit;
    logic                 par_good;
    logic                 timed_out;
    logic                 shift_en, par_en, commit, perr_set, ferr_set;
    logic                 good;

    sig_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ck_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (rxck),
        .rise (rck_rise)
    );

    // One flop longer than the bare synchroniser so data lines up with the registered edge pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) sd_pipe <= '1;
        else        sd_pipe <= {sd_pipe[SYNC_STAGES-1:0], rxsd};
    end
    assign sd = sd_pipe[SYNC_STAGES];

    assign par_good  = ((^{shreg, par_bit}) == !PARITY_EVEN);
    assign timed_out = (state != IDLE) && (to_cnt == TW'(TIMEOUT));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        commit    = 1'b0;
        perr_set  = 1'b0;
        ferr_set  = 1'b0;
        if (timed_out) begin
            state_nxt = IDLE;
            ferr_set  = 1'b1;
        end else if (rck_rise) begin
            case (state)
                IDLE: begin
                    if (sd == START_BIT) state_nxt = DATA;
                end
                DATA: begin
                    shift_en = 1'b1;
                    if (bit_cnt == CW'(DATA_W - 1)) state_nxt = PARITY;
                end
                PARITY: begin
                    par_en    = 1'b1;
                    state_nxt = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (sd != STOP_BIT) ferr_set = 1'b1;
                    else if (par_good)  commit   = 1'b1;
                    else                perr_set = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Frame assembly: shift register, bit counter and the mid-frame watchdog.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            to_cnt  <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            good    <= 1'b0;
        end else begin
            good <= commit;
            if (state == IDLE)  bit_cnt <= '0;
            else if (shift_en)  bit_cnt <= bit_cnt + CW'(1);
            if (state == IDLE || rck_rise)   to_cnt <= '0;
            else if (to_cnt != TW'(TIMEOUT)) to_cnt <= to_cnt + TW'(1);
            if (shift_en)
                shreg <= MSB_FIRST ? {shreg[DATA_W-2:0], sd} : {sd, shreg[DATA_W-1:1]};
            if (par_en) par_bit <= sd;
        end
    end

    // An accept coinciding with a commit frees the slot, so the new word loads without overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx.rx_data  <= '0;
            rx.rx_valid <= 1'b0;
            frame_cnt   <= '0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (perr_set) parity_err <= 1'b1;
            if (ferr_set) frame_err  <= 1'b1;
            if (good) begin
                if (!rx.rx_valid || rx.rx_ready) begin
                    rx.rx_data  <= shreg;
                    rx.rx_valid <= 1'b1;
                    frame_cnt   <= frame_cnt + 8'd1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx.rx_valid && rx.rx_ready) begin
                rx.rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sclk_frame_rx.sv
// Directed and randomized frames against a word-level model of the receiver's externally visible behaviour.
module tb_sclk_frame_rx;
    logic       clk;
    logic       rst_n;
    logic       rxsd;
    logic       rxck;
    logic       parity_err, frame_err, overrun, busy;
    logic [7:0] frame_cnt;

    sclk_frame_rx_if #(.DATA_W(16)) rx_if ();

    sclk_frame_rx #(.DATA_W(16), .SYNC_STAGES(2), .TIMEOUT(1024)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxsd      (rxsd),
        .rxck      (rxck),
        .rx        (rx_if.master),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun),
        .frame_cnt (frame_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic        ready_lvl = 1'b0;
    logic        exp_valid, exp_perr, exp_ferr, exp_ovr;
    logic [15:0] exp_data;
    logic [7:0]  exp_cnt;
    logic [15:0] exp_acc[$];
    logic [15:0] got_q[$];

    always @(posedge clk)
        if (rst_n && rx_if.rx_valid && rx_if.rx_ready) got_q.push_back(rx_if.rx_data);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_valid = 1'b0; exp_perr = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
        exp_data = 16'h0; exp_cnt = 8'd0;
    endtask

    task automatic set_ready(input logic r);
        @(negedge clk);
        ready_lvl = r;
        rx_if.rx_ready = r;
        if (r && exp_valid) begin
            exp_acc.push_back(exp_data);
            exp_valid = 1'b0;
        end
    endtask

    // A good frame is stored if the slot is free or being drained; otherwise it is dropped as overrun.
    task automatic model_frame(input logic [15:0] d, input bit flip);
        logic par;
        par = (^d) ^ flip;
        if ((($countones(d) + int'(par)) % 2) != 0) exp_perr = 1'b1;
        else if (exp_valid && !ready_lvl)           exp_ovr  = 1'b1;
        else begin
            exp_cnt = exp_cnt + 8'd1;
            if (ready_lvl) exp_acc.push_back(d);
            else begin
                exp_valid = 1'b1;
                exp_data  = d;
            end
        end
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0; rxsd = 1'b1; rxck = 1'b0;
        repeat (4) @(negedge clk);
        model_reset();
        check({tag, ".valid"}, rx_if.rx_valid, 0);
        check({tag, ".data"}, rx_if.rx_data, 0);
        check({tag, ".cnt"}, frame_cnt, 0);
        check({tag, ".flags"}, {parity_err, frame_err, overrun}, 0);
        check({tag, ".busy"}, busy, 0);
        rst_n = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        rxsd = b;
        repeat (4) @(negedge clk);
        rxck = 1'b1;
        repeat (4) @(negedge clk);
        rxck = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] d, input bit flip);
        send_bit(1'b0);
        for (int i = 15; i >= 0; i--) send_bit(d[i]);
        send_bit((^d) ^ flip);
        send_bit(1'b1);
        rxsd = 1'b1;
        repeat (8) @(negedge clk);
        model_frame(d, flip);
    endtask

    task automatic check_state(input string tag);
        check({tag, ".valid"}, rx_if.rx_valid, exp_valid);
        if (exp_valid) check({tag, ".data"}, rx_if.rx_data, exp_data);
        check({tag, ".cnt"}, frame_cnt, exp_cnt);
        check({tag, ".perr"}, parity_err, exp_perr);
        check({tag, ".ferr"}, frame_err, exp_ferr);
        check({tag, ".ovr"}, overrun, exp_ovr);
        check({tag, ".busy"}, busy, 0);
    endtask

    task automatic check_accepted(input string tag);
        check({tag, ".n"}, got_q.size(), exp_acc.size());
        for (int i = 0; i < got_q.size() && i < exp_acc.size(); i++)
            check({tag, ".word"}, got_q[i], exp_acc[i]);
        got_q.delete();
        exp_acc.delete();
    endtask

    initial begin
        rst_n = 1'b1; rxsd = 1'b1; rxck = 1'b0; rx_if.rx_ready = 1'b0;
        model_reset();

        apply_reset("reset");
        repeat (200) @(negedge clk);
        check_state("idle");

        send_frame(16'hA5C3, 1'b0);
        check_state("a5c3");
        set_ready(1'b1);
        set_ready(1'b0);
        check("a5c3.drain", rx_if.rx_valid, 0);

        send_frame(16'h0001, 1'b1);
        check_state("par_err");

        send_frame(16'h1234, 1'b0);
        send_frame(16'h5678, 1'b0);
        check_state("overrun");
        set_ready(1'b1);
        set_ready(1'b0);
        check_accepted("drain1");

        apply_reset("reset2");
        set_ready(1'b1);
        send_frame(16'h1234, 1'b0);
        send_frame(16'h5678, 1'b0);
        check_state("stream");
        check_accepted("stream");
        set_ready(1'b0);

        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        check("partial.busy", busy, 1);
        repeat (1100) @(negedge clk);
        exp_ferr = 1'b1;
        check_state("timeout");
        send_frame(16'hBEEF, 1'b0);
        check_state("beef");

        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(i[1]);
        check("midreset.busy", busy, 1);
        apply_reset("midreset");
        send_frame(16'hFFFF, 1'b0);
        check_state("ffff");

        for (int n = 0; n < 24; n++) begin
            logic [15:0] d;
            bit          flip;
            d    = 16'($urandom);
            flip = ($urandom_range(0, 7) == 0);
            set_ready(1'($urandom_range(0, 1)));
            send_frame(d, flip);
            check_state("rand");
        end
        set_ready(1'b1);
        set_ready(1'b0);
        check_accepted("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
